// File: rtl/load_stage.sv
// SHAKE load stage: packs message words into a rate-sized block, applies SHAKE
// padding (0x1F ... 0x80) and hands each block downstream over valid/ready.
module load_stage #(
  parameter int W        = 64,
  parameter int RATE_MAX = 1344
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        data_in,
  input  logic                valid_in,
  input  logic                last_in,
  input  logic [3:0]          last_bytes,
  input  logic [1:0]          operation_mode,
  output logic                ready_out,
  output logic [RATE_MAX-1:0] block_out,
  output logic                block_valid,
  input  logic                block_ready,
  output logic                last_block,
  output logic [1:0]          operation_mode_out
);

  localparam int SLOTS       = RATE_MAX / W;
  localparam int WORD_BYTES  = W / 8;
  localparam int CNT_W       = $clog2(SLOTS + 1);
  localparam int RATE_128    = 21;
  localparam int RATE_256    = 17;
  localparam int PAD_POS_128 = RATE_128 * W - 8;
  localparam int PAD_POS_256 = RATE_256 * W - 8;
  localparam logic [3:0] FULL_BYTES = 4'(WORD_BYTES);

  typedef enum logic {FILL, HOLD} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next, cnt_inc, last_slot;
  logic [RATE_MAX-1:0] blk, blk_next;
  logic                pad_pending, pad_pending_next;
  logic                in_msg, in_msg_next;
  logic                last_q, last_next;
  logic [1:0]          mode_q, mode_next;

  logic                accept;
  logic [1:0]          rate_mode;
  logic                is_128;
  logic [3:0]          lb_eff;
  logic                full_last;
  logic [W-1:0]        word_in;

  // ORs the 0x80 end-of-rate marker into the last byte of the active rate.
  function automatic logic [RATE_MAX-1:0] mark_rate_end(
    input logic [RATE_MAX-1:0] b,
    input logic                rate_128
  );
    logic [RATE_MAX-1:0] r;
    r = b;
    if (rate_128) r[PAD_POS_128 +: 8] = r[PAD_POS_128 +: 8] | 8'h80;
    else          r[PAD_POS_256 +: 8] = r[PAD_POS_256 +: 8] | 8'h80;
    return r;
  endfunction

  assign accept    = valid_in && ready_out;
  // The first word of a message decides the rate; afterwards the latched mode does.
  assign rate_mode = (state == FILL && !in_msg) ? operation_mode : mode_q;
  assign is_128    = (rate_mode == 2'b00);
  assign last_slot = is_128 ? CNT_W'(RATE_128 - 1) : CNT_W'(RATE_256 - 1);
  assign cnt_inc   = cnt + CNT_W'(1);
  assign lb_eff    = (last_bytes > FULL_BYTES) ? FULL_BYTES : last_bytes;
  assign full_last = last_in && (lb_eff == FULL_BYTES);

  // Incoming word with the domain byte already merged in for a short last word.
  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    word_in = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (!last_in || 4'(b) < lb_eff)  word_in[8*b +: 8] = data_in[8*b +: 8];
      else if (4'(b) == lb_eff)         word_in[8*b +: 8] = 8'h1F;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL: if (accept && (last_in || cnt == last_slot)) state_next = HOLD;
      HOLD: if (block_ready && !pad_pending)             state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    ready_out   = (state == FILL) && rst;
    block_valid = (state == HOLD);
  end

  // Datapath next-state: word packing, padding and block release.
  always_comb begin
    blk_next         = blk;
    cnt_next         = cnt;
    pad_pending_next = pad_pending;
    in_msg_next      = in_msg;
    last_next        = last_q;
    mode_next        = mode_q;
    case (state)
      FILL: begin
        if (accept) begin
          if (!in_msg) mode_next = operation_mode;
          for (int i = 0; i < SLOTS; i++) begin
            if (cnt == CNT_W'(i)) blk_next[i*W +: W] = word_in;
          end
          cnt_next = cnt_inc;
          if (last_in) begin
            in_msg_next = 1'b0;
            if (full_last && cnt == last_slot) begin
              // Message filled the block exactly: padding goes in a block of its own.
              pad_pending_next = 1'b1;
              last_next        = 1'b0;
            end else begin
              if (full_last) begin
                for (int i = 0; i < SLOTS; i++) begin
                  if (cnt_inc == CNT_W'(i)) blk_next[i*W +: 8] = 8'h1F;
                end
              end
              blk_next  = mark_rate_end(blk_next, is_128);
              last_next = 1'b1;
            end
          end else begin
            in_msg_next = 1'b1;
            last_next   = 1'b0;
          end
        end
      end
      HOLD: begin
        if (block_ready) begin
          blk_next = '0;
          cnt_next = '0;
          if (pad_pending) begin
            blk_next[7:0]    = 8'h1F;
            blk_next         = mark_rate_end(blk_next, is_128);
            last_next        = 1'b1;
            pad_pending_next = 1'b0;
          end else begin
            last_next = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: the block buffer is reset because its zero bytes are part of the padded output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk         <= '0;
      cnt         <= '0;
      pad_pending <= 1'b0;
      in_msg      <= 1'b0;
      last_q      <= 1'b0;
      mode_q      <= 2'b00;
    end else begin
      blk         <= blk_next;
      cnt         <= cnt_next;
      pad_pending <= pad_pending_next;
      in_msg      <= in_msg_next;
      last_q      <= last_next;
      mode_q      <= mode_next;
    end
  end

  assign block_out          = blk;
  assign last_block         = last_q;
  assign operation_mode_out = mode_q;

endmodule

// File: tb/tb_load_stage.sv
// Self-checking bench for load_stage: random messages compared against a
// byte-stream SHAKE padding model, plus directed boundary and reset cases.
module tb_load_stage;

  localparam int RATE_MAX = 1344;

  logic                clk;
  logic                rst;
  logic [63:0]         data_in;
  logic                valid_in;
  logic                last_in;
  logic [3:0]          last_bytes;
  logic [1:0]          operation_mode;
  logic                ready_out;
  logic [RATE_MAX-1:0] block_out;
  logic                block_valid;
  logic                block_ready;
  logic                last_block;
  logic [1:0]          operation_mode_out;

  load_stage dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .last_in(last_in),
    .last_bytes(last_bytes), .operation_mode(operation_mode), .ready_out(ready_out),
    .block_out(block_out), .block_valid(block_valid), .block_ready(block_ready),
    .last_block(last_block), .operation_mode_out(operation_mode_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [RATE_MAX-1:0] data;
    logic                last;
    logic [1:0]          mode;
  } blk_t;

  blk_t exp_q[$];
  int   checks      = 0;
  int   failures    = 0;
  int   hold_cycles = 0;

  task automatic check(input string tag, input logic [RATE_MAX-1:0] obs, input logic [RATE_MAX-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: standard SHAKE pad10*1 over the byte stream, cut into rate-sized blocks.
  task automatic add_expected(input logic [7:0] msg[$], input logic [1:0] mode);
    int         rb;
    logic [7:0] p[$];
    rb = (mode == 2'b00) ? 168 : 136;
    p = msg;
    p.push_back(8'h1F);
    while (p.size() % rb != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    for (int s = 0; s < p.size(); s += rb) begin
      blk_t b;
      b.data = '0;
      for (int k = 0; k < rb; k++) b.data[8*k +: 8] = p[s+k];
      b.last = (s + rb == p.size());
      b.mode = mode;
      exp_q.push_back(b);
    end
  endtask

  task automatic service_block();
    blk_t                e;
    logic [RATE_MAX-1:0] snap;
    if (exp_q.size() == 0) begin
      check("unexpected_block", block_valid, 0);
    end else begin
      e = exp_q.pop_front();
      check("block_data", block_out, e.data);
      check("last_block", last_block, e.last);
      check("mode_out", operation_mode_out, e.mode);
      check("ready_in_hold", ready_out, 0);
    end
    snap = block_out;
    block_ready = 1'b0;
    for (int c = 0; c < hold_cycles; c++) begin
      @(posedge clk); @(negedge clk);
      check("hold_valid", block_valid, 1);
      check("hold_ready", ready_out, 0);
      check("hold_stable", block_out, snap);
    end
    block_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    block_ready = 1'b0;
  endtask

  // Presents one word (kept valid through any HOLD) and waits for its acceptance.
  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] lb,
                           input logic [1:0] m, input logic expect_block);
    int guard;
    guard = 0;
    data_in = d; last_in = last; last_bytes = lb; operation_mode = m; valid_in = 1'b1;
    while (ready_out !== 1'b1 && guard < 40) begin
      if (block_valid === 1'b1) service_block();
      else begin @(posedge clk); @(negedge clk); end
      guard++;
    end
    if (ready_out !== 1'b1) begin
      check("accept_timeout", ready_out, 1);
      valid_in = 1'b0;
    end else begin
      @(posedge clk); @(negedge clk);
      valid_in = 1'b0; last_in = 1'b0;
      if (expect_block) check("block_latency", block_valid, 1);
      else              check("ready_after_word", ready_out, 1);
    end
  endtask

  task automatic drain();
    int guard;
    while (exp_q.size() > 0) begin
      guard = 0;
      while (block_valid !== 1'b1 && guard < 20) begin
        @(posedge clk); @(negedge clk);
        guard++;
      end
      if (block_valid !== 1'b1) begin
        check("drain_timeout", block_valid, 1);
        exp_q.delete();
      end else begin
        service_block();
      end
    end
    check("idle_ready", ready_out, 1);
    check("idle_valid", block_valid, 0);
  endtask

  task automatic send_message(input logic [1:0] mode, input int nwords, input logic [3:0] lb,
                              input int hold, input bit do_drain,
                              input bit fix_last, input logic [63:0] last_word);
    logic [63:0] words[$];
    logic [7:0]  msg[$];
    int          rate, nb;
    logic [1:0]  m;
    rate = (mode == 2'b00) ? 21 : 17;
    for (int j = 0; j < nwords; j++) words.push_back({$urandom(), $urandom()});
    if (fix_last) words[nwords-1] = last_word;
    for (int j = 0; j < nwords; j++) begin
      nb = (j < nwords - 1) ? 8 : ((lb > 4'd8) ? 8 : int'(lb));
      for (int k = 0; k < nb; k++) msg.push_back(words[j][8*k +: 8]);
    end
    add_expected(msg, mode);
    hold_cycles = hold;
    for (int j = 0; j < nwords; j++) begin
      m = (j == 0) ? mode : 2'($urandom_range(0, 3));
      send_word(words[j], j == nwords - 1,
                (j == nwords - 1) ? lb : 4'($urandom_range(0, 15)), m,
                (j == nwords - 1) || ((j + 1) % rate == 0));
    end
    if (do_drain) drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready_out, 0);
    check({tag, "_valid"}, block_valid, 0);
    check({tag, "_last"}, last_block, 0);
    check({tag, "_mode"}, operation_mode_out, 0);
    check({tag, "_block"}, block_out, '0);
  endtask

  initial begin
    rst = 1'b0; valid_in = 1'b0; last_in = 1'b0; data_in = '0; last_bytes = '0;
    operation_mode = 2'b00; block_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", ready_out, 1);

    // Empty SHAKE128 message: single padding block.
    send_message(2'b00, 1, 4'd0, 0, 1, 0, '0);

    // SHAKE256, 3 words, last has 3 bytes 0xAABBCC.
    send_message(2'b01, 3, 4'd3, 1, 0, 1, {40'hDEADBEEF55, 24'hAABBCC});
    check("slot2_pad", block_out[191:128], 64'h000000001FAABBCC);
    check("above_rate_zero", block_out[RATE_MAX-1:1088], '0);
    drain();

    // SHAKE128 exact block: data block then separate padding block.
    send_message(2'b00, 21, 4'd8, 1, 1, 0, '0);

    // SHAKE256, 17 words ending with 7 bytes: 0x9F at byte 135.
    send_message(2'b01, 17, 4'd7, 0, 0, 0, '0);
    check("byte135_9f", block_out[1087:1080], 8'h9F);
    drain();

    // Backpressure: 10-cycle HOLD with the next word waiting on valid_in.
    send_message(2'b01, 20, 4'd5, 10, 1, 0, '0);

    // Illegal last_bytes treated as 8; mode 10 behaves as SHAKE256.
    send_message(2'b10, 5, 4'd13, 0, 1, 0, '0);

    // Full last word below the rate end: 0x1F lands at byte 0 of the next slot.
    send_message(2'b00, 7, 4'd8, 2, 1, 0, '0);

    for (int t = 0; t < 8; t++) begin
      send_message(2'($urandom_range(0, 3)), $urandom_range(1, 45),
                   4'($urandom_range(0, 10)), $urandom_range(0, 3), 1, 0, '0);
    end

    // Reset after 5 words of a SHAKE128 message.
    for (int j = 0; j < 5; j++)
      send_word({$urandom(), $urandom()}, 1'b0, 4'd0, (j == 0) ? 2'b00 : 2'b01, 1'b0);
    #2 rst = 1'b0;
    #1 check_reset_outputs("mid_msg_reset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_message(2'b01, 2, 4'd5, 1, 1, 0, '0);

    // Reset while a SHAKE256 block is held.
    send_message(2'b01, 4, 4'd8, 0, 0, 0, '0);
    check("hold_before_reset", operation_mode_out, 2'b01);
    #2 rst = 1'b0;
    #1 check_reset_outputs("hold_reset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_message(2'b00, 3, 4'd2, 0, 1, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
